// File: rtl/terminal_cajero_if.sv
// Keypad/card-slot side and controller-response bundle of the ATM terminal.
// master = terminal_cajero, slave = controller/customer environment.
interface terminal_cajero_if;
    logic        TARJETA_IN;
    logic        SEL_TRANS;
    logic        TECLA_STB;
    logic [3:0]  TECLA;
    logic        PIN_INCORRECTO;
    logic        ADVERTENCIA;
    logic        BLOQUEO;
    logic        BALANCE_ACTUALIZADO;
    logic        ENTREGAR_DINERO;
    logic        FONDOS_INSUFICIENTES;
    logic        TARJETA_RECIBIDA;
    logic        TIPO_TRANS;
    logic        DIGITO_STB;
    logic [3:0]  DIGITO;
    logic        MONTO_STB;
    logic [31:0] MONTO;
    logic        EXPULSAR_TARJETA;
    logic [2:0]  ESTADO;

    modport master (
        input  TARJETA_IN, SEL_TRANS, TECLA_STB, TECLA,
        input  PIN_INCORRECTO, ADVERTENCIA, BLOQUEO,
        input  BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES,
        output TARJETA_RECIBIDA, TIPO_TRANS, DIGITO_STB, DIGITO,
        output MONTO_STB, MONTO, EXPULSAR_TARJETA, ESTADO
    );

    modport slave (
        output TARJETA_IN, SEL_TRANS, TECLA_STB, TECLA,
        output PIN_INCORRECTO, ADVERTENCIA, BLOQUEO,
        output BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES,
        input  TARJETA_RECIBIDA, TIPO_TRANS, DIGITO_STB, DIGITO,
        input  MONTO_STB, MONTO, EXPULSAR_TARJETA, ESTADO
    );
endinterface

// File: rtl/terminal_cajero.sv
// ATM customer-side front end: card slot + keypad to controller sequencing.
// Optional inactivity timeout enabled by defining TERMINAL_TIMEOUT_EN.
module terminal_cajero #(
    parameter int RESP_CICLOS  = 4,
    parameter int INACT_CICLOS = 1000
) (
    input logic               CLK,
    input logic               RESET,
    terminal_cajero_if.master bus
);

    typedef enum logic [2:0] {
        ESPERA_TARJETA = 3'd0,
        PIN            = 3'd1,
        ESPERA_PIN     = 3'd2,
        MONTO_CAP      = 3'd3,
        ESPERA_RES     = 3'd4,
        BLOQUEADO      = 3'd5,
        FIN            = 3'd6
    } estado_t;

    localparam int RW = $clog2(RESP_CICLOS + 1);

    estado_t       estado;
    logic          tarjeta_q;
    logic          tarjeta_qq;
    logic [3:0]    dig_cnt;
    logic [RW-1:0] resp_cnt;
    logic [31:0]   acc;

    logic sube;
    logic baja;
    logic es_digito;
    logic es_enter;
    logic es_cancel;
    logic resp_flag;
    logic inact_fin;
    logic ir_fin;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tarjeta_q  <= 1'b0;
            tarjeta_qq <= 1'b0;
        end else begin
            tarjeta_q  <= bus.TARJETA_IN;
            tarjeta_qq <= tarjeta_q;
        end
    end

    assign sube      = tarjeta_q & ~tarjeta_qq;
    assign baja      = ~tarjeta_q & tarjeta_qq;
    assign es_digito = bus.TECLA_STB && (bus.TECLA <= 4'd9);
    assign es_enter  = bus.TECLA_STB && (bus.TECLA == 4'hA);
    assign es_cancel = bus.TECLA_STB && (bus.TECLA == 4'hB);
    assign resp_flag = bus.ENTREGAR_DINERO | bus.BALANCE_ACTUALIZADO
                     | bus.FONDOS_INSUFICIENTES;

`ifdef TERMINAL_TIMEOUT_EN
    localparam int IW = $clog2(INACT_CICLOS + 1);

    logic [IW-1:0] inact_cnt;
    logic          en_sesion;

    assign en_sesion = (estado == PIN) || (estado == ESPERA_PIN)
                    || (estado == MONTO_CAP);
    assign inact_fin = en_sesion && (inact_cnt == IW'(INACT_CICLOS));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            inact_cnt <= '0;
        end else if (!en_sesion || bus.TECLA_STB) begin
            inact_cnt <= '0;
        end else if (!inact_fin) begin
            inact_cnt <= inact_cnt + 1'b1;
        end
    end
`else
    assign inact_fin = 1'b0;
`endif

    // Every session-terminating event funnels through here so the eject
    // pulse, session drop and amount clear always happen together.
    always_comb begin
        ir_fin = 1'b0;
        unique case (estado)
            PIN, MONTO_CAP:
                ir_fin = es_cancel | baja | inact_fin;
            ESPERA_PIN:
                ir_fin = !bus.BLOQUEO && !bus.PIN_INCORRECTO
                      && (es_cancel | baja | inact_fin);
            ESPERA_RES:
                ir_fin = resp_flag | baja;
            default:
                ir_fin = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            estado               <= ESPERA_TARJETA;
            dig_cnt              <= '0;
            resp_cnt             <= '0;
            acc                  <= '0;
            bus.TARJETA_RECIBIDA <= 1'b0;
            bus.TIPO_TRANS       <= 1'b0;
            bus.DIGITO_STB       <= 1'b0;
            bus.DIGITO           <= '0;
            bus.MONTO_STB        <= 1'b0;
            bus.MONTO            <= '0;
            bus.EXPULSAR_TARJETA <= 1'b0;
        end else begin
            bus.DIGITO_STB       <= 1'b0;
            bus.MONTO_STB        <= 1'b0;
            bus.EXPULSAR_TARJETA <= 1'b0;
            if (ir_fin) begin
                estado               <= FIN;
                bus.EXPULSAR_TARJETA <= 1'b1;
                bus.TARJETA_RECIBIDA <= 1'b0;
                bus.MONTO            <= '0;
            end else begin
                unique case (estado)
                    ESPERA_TARJETA: begin
                        if (sube) begin
                            bus.TIPO_TRANS       <= bus.SEL_TRANS;
                            bus.TARJETA_RECIBIDA <= 1'b1;
                            dig_cnt              <= '0;
                            estado               <= PIN;
                        end
                    end
                    PIN: begin
                        if (es_digito) begin
                            bus.DIGITO     <= bus.TECLA;
                            bus.DIGITO_STB <= 1'b1;
                            if (dig_cnt == 4'd3) begin
                                dig_cnt  <= '0;
                                resp_cnt <= '0;
                                estado   <= ESPERA_PIN;
                            end else begin
                                dig_cnt <= dig_cnt + 4'd1;
                            end
                        end
                    end
                    ESPERA_PIN: begin
                        if (bus.BLOQUEO) begin
                            estado <= BLOQUEADO;
                        end else if (bus.PIN_INCORRECTO) begin
                            dig_cnt <= '0;
                            estado  <= PIN;
                        end else if (resp_cnt == RW'(RESP_CICLOS - 1)) begin
                            acc     <= '0;
                            dig_cnt <= '0;
                            estado  <= MONTO_CAP;
                        end else begin
                            resp_cnt <= resp_cnt + 1'b1;
                        end
                    end
                    MONTO_CAP: begin
                        // Nine decimal digits max keeps acc below 2^32.
                        if (es_digito && dig_cnt < 4'd9) begin
                            acc     <= acc * 32'd10 + {28'd0, bus.TECLA};
                            dig_cnt <= dig_cnt + 4'd1;
                        end else if (es_enter && dig_cnt != 4'd0) begin
                            bus.MONTO     <= acc;
                            bus.MONTO_STB <= 1'b1;
                            estado        <= ESPERA_RES;
                        end
                    end
                    ESPERA_RES: begin
                        estado <= ESPERA_RES;
                    end
                    BLOQUEADO: begin
                        estado <= BLOQUEADO;
                    end
                    FIN: begin
                        if (!tarjeta_q) begin
                            estado <= ESPERA_TARJETA;
                        end
                    end
                    default: begin
                        estado <= ESPERA_TARJETA;
                    end
                endcase
            end
        end
    end

    assign bus.ESTADO = estado;

endmodule

// File: tb/tb_terminal_cajero.sv
// Directed bench for terminal_cajero: card sessions, PIN, amount and ejection.
// Build with or without TERMINAL_TIMEOUT_EN; idle check adapts to the macro.
module tb_terminal_cajero;

    logic clk;
    logic rst;
    int   vectors;
    int   errs;

    terminal_cajero_if bus ();

    terminal_cajero #(
        .RESP_CICLOS (4),
        .INACT_CICLOS(20)
    ) dut (
        .CLK  (clk),
        .RESET(rst),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic key(input logic [3:0] k);
        bus.TECLA_STB = 1'b1;
        bus.TECLA     = k;
        tick();
        bus.TECLA_STB = 1'b0;
    endtask

    task automatic insert(input logic sel);
        bus.SEL_TRANS  = sel;
        bus.TARJETA_IN = 1'b1;
        tick();
        tick();
    endtask

    task automatic remove();
        bus.TARJETA_IN = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int n;
        int seen;
        vectors = 0;
        errs    = 0;
        rst                      = 1'b1;
        bus.TARJETA_IN           = 1'b0;
        bus.SEL_TRANS            = 1'b0;
        bus.TECLA_STB            = 1'b0;
        bus.TECLA                = 4'd0;
        bus.PIN_INCORRECTO       = 1'b0;
        bus.ADVERTENCIA          = 1'b0;
        bus.BLOQUEO              = 1'b0;
        bus.BALANCE_ACTUALIZADO  = 1'b0;
        bus.ENTREGAR_DINERO      = 1'b0;
        bus.FONDOS_INSUFICIENTES = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        chk("rst_estado", 32'(bus.ESTADO), 0);
        chk("rst_recibida", 32'(bus.TARJETA_RECIBIDA), 0);
        chk("rst_tipo", 32'(bus.TIPO_TRANS), 0);
        chk("rst_digito", 32'(bus.DIGITO), 0);
        chk("rst_monto", bus.MONTO, 0);
        chk("rst_strobes", 32'({bus.DIGITO_STB, bus.MONTO_STB,
                               bus.EXPULSAR_TARJETA}), 0);

        // Session 1: withdrawal, PIN 1234, amount 500, cash delivered
        bus.SEL_TRANS  = 1'b1;
        bus.TARJETA_IN = 1'b1;
        tick();
        chk("ins_lat1", 32'(bus.TARJETA_RECIBIDA), 0);
        tick();
        chk("ins_lat2", 32'(bus.TARJETA_RECIBIDA), 1);
        chk("ins_tipo", 32'(bus.TIPO_TRANS), 1);
        chk("ins_estado", 32'(bus.ESTADO), 1);
        bus.SEL_TRANS = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            key(4'(i));
            chk("pin_stb", 32'(bus.DIGITO_STB), 1);
            chk("pin_dig", 32'(bus.DIGITO), 32'(i));
        end
        chk("espera_pin", 32'(bus.ESTADO), 2);
        tick();
        tick();
        tick();
        chk("resp_3cyc", 32'(bus.ESTADO), 2);
        tick();
        chk("resp_4cyc", 32'(bus.ESTADO), 3);
        key(4'd5);
        chk("amt_no_dstb", 32'(bus.DIGITO_STB), 0);
        key(4'd0);
        key(4'd0);
        key(4'hA);
        chk("monto_stb", 32'(bus.MONTO_STB), 1);
        chk("monto_500", bus.MONTO, 500);
        chk("espera_res", 32'(bus.ESTADO), 4);
        tick();
        chk("monto_stb_1cyc", 32'(bus.MONTO_STB), 0);
        chk("monto_hold", bus.MONTO, 500);
        key(4'hB);
        chk("res_cancel_ign", 32'(bus.ESTADO), 4);
        bus.ENTREGAR_DINERO = 1'b1;
        tick();
        bus.ENTREGAR_DINERO = 1'b0;
        chk("ent_eject", 32'(bus.EXPULSAR_TARJETA), 1);
        chk("ent_recibida", 32'(bus.TARJETA_RECIBIDA), 0);
        chk("ent_monto0", bus.MONTO, 0);
        chk("ent_fin", 32'(bus.ESTADO), 6);
        tick();
        chk("eject_1cyc", 32'(bus.EXPULSAR_TARJETA), 0);
        chk("fin_hold", 32'(bus.ESTADO), 6);
        remove();
        chk("back_idle", 32'(bus.ESTADO), 0);

        // Session 2: wrong PIN, re-entry, 9-digit amount, no funds
        insert(1'b0);
        chk("s2_tipo", 32'(bus.TIPO_TRANS), 0);
        for (int i = 0; i < 4; i++) key(4'd9);
        tick();
        bus.PIN_INCORRECTO = 1'b1;
        tick();
        bus.PIN_INCORRECTO = 1'b0;
        chk("pin_bad", 32'(bus.ESTADO), 1);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            key(4'd3);
            n += int'(bus.DIGITO_STB);
        end
        chk("reentry_stbs", 32'(n), 4);
        chk("reentry_estado", 32'(bus.ESTADO), 2);
        repeat (4) tick();
        key(4'hA);
        chk("empty_enter", 32'(bus.MONTO_STB), 0);
        chk("empty_estado", 32'(bus.ESTADO), 3);
        for (int i = 1; i <= 9; i++) key(4'(i));
        key(4'd7);
        key(4'hA);
        chk("monto_9dig", bus.MONTO, 123456789);
        chk("monto9_stb", 32'(bus.MONTO_STB), 1);
        bus.FONDOS_INSUFICIENTES = 1'b1;
        tick();
        bus.FONDOS_INSUFICIENTES = 1'b0;
        chk("fondos_fin", 32'(bus.ESTADO), 6);
        chk("fondos_eject", 32'(bus.EXPULSAR_TARJETA), 1);
        remove();

        // Session 3: block wins over wrong PIN, card retained until reset
        insert(1'b1);
        for (int i = 0; i < 4; i++) key(4'd7);
        bus.BLOQUEO        = 1'b1;
        bus.PIN_INCORRECTO = 1'b1;
        tick();
        bus.BLOQUEO        = 1'b0;
        bus.PIN_INCORRECTO = 1'b0;
        chk("bloq_estado", 32'(bus.ESTADO), 5);
        n = 0;
        key(4'd1);
        n += int'(bus.DIGITO_STB) + int'(bus.EXPULSAR_TARJETA);
        key(4'hA);
        n += int'(bus.DIGITO_STB) + int'(bus.EXPULSAR_TARJETA);
        key(4'hB);
        n += int'(bus.DIGITO_STB) + int'(bus.EXPULSAR_TARJETA);
        bus.TARJETA_IN = 1'b0;
        tick();
        tick();
        n += int'(bus.EXPULSAR_TARJETA);
        chk("bloq_quiet", 32'(n), 0);
        chk("bloq_retain", 32'(bus.TARJETA_RECIBIDA), 1);
        chk("bloq_stays", 32'(bus.ESTADO), 5);
        rst = 1'b1;
        #1;
        chk("async_estado", 32'(bus.ESTADO), 0);
        chk("async_outs", 32'({bus.TARJETA_RECIBIDA, bus.TIPO_TRANS,
                              bus.DIGITO, bus.EXPULSAR_TARJETA}), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst", 32'(bus.ESTADO), 0);

        // Session 4: cancel after two PIN digits
        insert(1'b0);
        key(4'd1);
        key(4'd2);
        key(4'hB);
        chk("cancel_eject", 32'(bus.EXPULSAR_TARJETA), 1);
        chk("cancel_recib", 32'(bus.TARJETA_RECIBIDA), 0);
        chk("cancel_fin", 32'(bus.ESTADO), 6);
        remove();

        // Session 5: card pulled mid-PIN
        insert(1'b0);
        key(4'd4);
        bus.TARJETA_IN = 1'b0;
        tick();
        tick();
        chk("pull_eject", 32'(bus.EXPULSAR_TARJETA), 1);
        chk("pull_fin", 32'(bus.ESTADO), 6);
        tick();
        chk("pull_idle", 32'(bus.ESTADO), 0);

        // Session 6: idle in amount capture
        insert(1'b0);
        for (int i = 0; i < 4; i++) key(4'd2);
        repeat (4) tick();
        chk("idle_start", 32'(bus.ESTADO), 3);
`ifdef TERMINAL_TIMEOUT_EN
        seen = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            tick();
            if (bus.EXPULSAR_TARJETA) seen = 1;
        end
        chk("timeout_eject", 32'(seen), 1);
        chk("timeout_fin", 32'(bus.ESTADO), 6);
`else
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            seen += int'(bus.EXPULSAR_TARJETA);
        end
        chk("no_timeout_ej", 32'(seen), 0);
        chk("no_timeout", 32'(bus.ESTADO), 3);
        key(4'hB);
        chk("idle_cancel", 32'(bus.EXPULSAR_TARJETA), 1);
`endif
        remove();
        chk("final_idle", 32'(bus.ESTADO), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
